// File: rtl/sc_fifo_flags_if.sv
// sc_fifo_flags_if: push/pop/flush handshake and status bundle for sc_fifo_flags.
interface sc_fifo_flags_if #(parameter int AW = 3, parameter int DW = 8);
    logic          clr;
    logic          push;
    logic [DW-1:0] wdata;
    logic          pop;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          almost_empty;
    logic          almost_full;
    logic          overflow;
    logic          underflow;
    modport master (
        output clr, push, wdata, pop,
        input  rdata, rvalid, count, empty, full, almost_empty, almost_full, overflow, underflow
    );
    modport slave (
        input  clr, push, wdata, pop,
        output rdata, rvalid, count, empty, full, almost_empty, almost_full, overflow, underflow
    );
endinterface

// File: rtl/sc_fifo_flags.sv
// sc_fifo_flags: single-clock FIFO with count, almost flags, flush and sticky errors.
// Define SC_FIFO_FWFT_EN for first-word-fall-through reads; registered reads otherwise.
module sc_fifo_flags #(
    parameter int AW        = 3,
    parameter int DW        = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 1
) (
    input logic           clk,
    input logic           rst,
    sc_fifo_flags_if.slave f
);
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW + 1)'(AF_THRESH);
    localparam logic [AW:0] AE_C    = (AW + 1)'(AE_THRESH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wp_q, wp_d, rp_q, rp_d, count_q, count_d;
    logic          empty_q, empty_d, full_q, full_d, ae_q, ae_d, af_q, af_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic          pop_ok, push_ok;

    always_comb begin
        pop_ok  = f.pop & ~empty_q;
        push_ok = f.push & (~full_q | pop_ok);
        wp_d    = f.clr ? '0 : wp_q + {{AW{1'b0}}, push_ok};
        rp_d    = f.clr ? '0 : rp_q + {{AW{1'b0}}, pop_ok};
        count_d = f.clr ? '0 : count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        empty_d = count_d == '0;
        full_d  = count_d == DEPTH_C;
        ae_d    = count_d <= AE_C;
        af_d    = count_d >= AF_C;
        ovf_d   = ~f.clr & (ovf_q | (f.push & ~push_ok));
        udf_d   = ~f.clr & (udf_q | (f.pop & empty_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ae_q    <= 1'b1;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ae_q    <= ae_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is deliberately not reset; only accepted, unflushed pushes write it.
    always_ff @(posedge clk) begin
        if (!rst && !f.clr && push_ok) mem_q[wp_q[AW-1:0]] <= f.wdata;
    end

`ifdef SC_FIFO_FWFT_EN
    assign f.rdata  = mem_q[rp_q[AW-1:0]];
    assign f.rvalid = ~empty_q;
`else
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;

    always_comb begin
        rdata_d  = (pop_ok & ~f.clr) ? mem_q[rp_q[AW-1:0]] : rdata_q;
        rvalid_d = pop_ok & ~f.clr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign f.rdata  = rdata_q;
    assign f.rvalid = rvalid_q;
`endif

    assign f.count        = count_q;
    assign f.empty        = empty_q;
    assign f.full         = full_q;
    assign f.almost_empty = ae_q;
    assign f.almost_full  = af_q;
    assign f.overflow     = ovf_q;
    assign f.underflow    = udf_q;
endmodule

// File: tb/tb_sc_fifo_flags.sv
// tb_sc_fifo_flags: random and directed stimulus against a queue-based FIFO model.
module tb_sc_fifo_flags;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    sc_fifo_flags_if #(.AW(3), .DW(8)) f ();
    sc_fifo_flags dut (.clk(clk), .rst(rst), .f(f));

    always #5 clk = ~clk;

    logic [7:0] q[$];
    bit         ovf, udf, ev;
    logic [7:0] er;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("count", 32'(f.count), q.size());
        chk("empty", 32'(f.empty), 32'(q.size() == 0));
        chk("full", 32'(f.full), 32'(q.size() == 8));
        chk("almost_empty", 32'(f.almost_empty), 32'(q.size() <= 1));
        chk("almost_full", 32'(f.almost_full), 32'(q.size() >= 6));
        chk("overflow", 32'(f.overflow), 32'(ovf));
        chk("underflow", 32'(f.underflow), 32'(udf));
`ifdef SC_FIFO_FWFT_EN
        chk("rvalid", 32'(f.rvalid), 32'(q.size() > 0));
        if (q.size() > 0) chk("rdata", 32'(f.rdata), 32'(q[0]));
`else
        chk("rvalid", 32'(f.rvalid), 32'(ev));
        chk("rdata", 32'(f.rdata), 32'(er));
`endif
    endtask

    task automatic cyc(input bit ps, input bit pp, input bit cl, input logic [7:0] wd);
        bit pok, wok;
        f.push = ps;
        f.pop = pp;
        f.clr = cl;
        f.wdata = wd;
        if (cl) begin
            q.delete();
            ovf = 0;
            udf = 0;
            ev = 0;
        end else begin
            pok = pp && q.size() > 0;
            wok = ps && (q.size() < 8 || pok);
            if (ps && !wok) ovf = 1;
            if (pp && q.size() == 0) udf = 1;
            ev = pok;
            if (pok) er = q.pop_front();
            if (wok) q.push_back(wd);
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset(input bit ps);
        rst = 1'b1;
        f.push = ps;
        f.pop = 1'b1;
        f.clr = 1'b1;
        f.wdata = 8'hEE;
        q.delete();
        ovf = 0;
        udf = 0;
        ev = 0;
        er = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        f.push = 0;
        f.pop = 0;
        f.clr = 0;
        f.wdata = 0;
        do_reset(1'b0);
        for (int i = 1; i <= 8; i++) cyc(1, 0, 0, 8'(i));
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 8'h00);
        cyc(0, 0, 0, 8'h00);
        for (int i = 1; i <= 8; i++) cyc(1, 0, 0, 8'(i));
        cyc(1, 1, 0, 8'hAA);
        cyc(1, 0, 0, 8'h55);
        for (int i = 0; i < 9; i++) cyc(0, 1, 0, 8'h00);
        cyc(0, 0, 0, 8'h00);
        cyc(1, 1, 0, 8'h33);
        for (int i = 0; i < 20; i++) cyc(1, (i % 4) != 0, 0, 8'(8'h80 + i));
        for (int i = 0; i < 20; i++) cyc((i % 4) == 0, 1, 0, 8'(8'hC0 + i));
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 8'(8'h10 + i));
        cyc(1, 0, 1, 8'h99);
        cyc(0, 1, 0, 8'h00);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'(8'h20 + i));
        do_reset(1'b1);
        cyc(0, 1, 0, 8'h00);
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                $urandom_range(0, 99) < 2, 8'($urandom));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
